// File: rtl/lockstep_pkg.sv
// Shared types for the lockstep data responder: FSM states and the
// normalised request record compared between the two cores.
package lockstep_pkg;

    // Requests are zero-extended into fixed-width records so one comparator
    // type serves every ADDR_WIDTH/DATA_WIDTH up to these limits.
    localparam int unsigned REQ_ADDR_MAX = 64;
    localparam int unsigned REQ_DATA_MAX = 64;
    localparam int unsigned BE_WIDTH     = REQ_DATA_MAX / 8;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        MEM,
        RESP
    } state_e;

    typedef struct packed {
        logic                    we;
        logic [BE_WIDTH-1:0]     be;
        logic [REQ_ADDR_MAX-1:0] addr;
        logic [REQ_DATA_MAX-1:0] wdata;
    } req_t;

endpackage

// File: rtl/lockstep_req_cmp.sv
// Combinational agreement check between the primary and shadow requests.
// Write data only takes part when the access is a write.
module lockstep_req_cmp
    import lockstep_pkg::*;
(
    input  req_t a_i,
    input  req_t b_i,
    output logic match_o
);

    // Control fields must always agree; wdata only matters for writes.
    always_comb begin
        match_o = (a_i.we == b_i.we) && (a_i.be == b_i.be) && (a_i.addr == b_i.addr) &&
                  (!a_i.we || (a_i.wdata == b_i.wdata));
    end

endmodule

// File: rtl/lockstep_data_responder.sv
// Responder for a lockstep core pair: waits for both data requests (bounded
// skew), compares them, performs one memory access on agreement and returns
// an identical response to both cores. Disagreement suppresses the access.
module lockstep_data_responder
    import lockstep_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SKEW_MAX   = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    a_req_i,
    input  logic                    b_req_i,
    output logic                    a_gnt_o,
    output logic                    b_gnt_o,
    output logic                    a_rvalid_o,
    output logic                    b_rvalid_o,
    input  logic                    a_we_i,
    input  logic                    b_we_i,
    input  logic [DATA_WIDTH/8-1:0] a_be_i,
    input  logic [DATA_WIDTH/8-1:0] b_be_i,
    input  logic [ADDR_WIDTH-1:0]   a_addr_i,
    input  logic [ADDR_WIDTH-1:0]   b_addr_i,
    input  logic [DATA_WIDTH-1:0]   a_wdata_i,
    input  logic [DATA_WIDTH-1:0]   b_wdata_i,
    output logic [DATA_WIDTH-1:0]   a_rdata_o,
    output logic [DATA_WIDTH-1:0]   b_rdata_o,
    output logic                    a_err_o,
    output logic                    b_err_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    mismatch_o,
    output logic                    skew_timeout_o,
    output logic [CNT_WIDTH-1:0]    mismatch_cnt_o
);

    localparam int unsigned BE_W = DATA_WIDTH / 8;
    localparam int unsigned SK_W = $clog2(SKEW_MAX + 1);

    state_e                 state_q, state_d;
    logic [SK_W-1:0]        skew_q, skew_d;
    logic                   lone_a_q, lone_a_d;
    logic                   quiet_q;
    logic                   rv_a_q, rv_a_d, rv_b_q, rv_b_d, err_q, err_d;
    logic                   we_q;
    logic [BE_W-1:0]        be_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic                   gnt_a, gnt_b, lat, mismatch, timeout, match, live;
    logic                   in_mem, in_resp;
    req_t                   req_a, req_b;

    // Normalise both cores' fields into comparator records.
    always_comb begin
        req_a = '{we: a_we_i, be: BE_WIDTH'(a_be_i), addr: REQ_ADDR_MAX'(a_addr_i),
                  wdata: REQ_DATA_MAX'(a_wdata_i)};
        req_b = '{we: b_we_i, be: BE_WIDTH'(b_be_i), addr: REQ_ADDR_MAX'(b_addr_i),
                  wdata: REQ_DATA_MAX'(b_wdata_i)};
    end

    lockstep_req_cmp u_cmp (
        .a_i     (req_a),
        .b_i     (req_b),
        .match_o (match)
    );

    // Requests are ignored while in reset and for the one quiet cycle after it.
    assign live = !rst_i && !quiet_q;

    // Next-state, grant and event decode.
    always_comb begin
        state_d  = state_q;
        skew_d   = skew_q;
        lone_a_d = lone_a_q;
        rv_a_d   = rv_a_q;
        rv_b_d   = rv_b_q;
        err_d    = err_q;
        gnt_a    = 1'b0;
        gnt_b    = 1'b0;
        lat      = 1'b0;
        mismatch = 1'b0;
        timeout  = 1'b0;
        if (live) begin
            case (state_q)
                IDLE, SYNC: begin
                    if (a_req_i && b_req_i) begin
                        gnt_a    = 1'b1;
                        gnt_b    = 1'b1;
                        lat      = 1'b1;
                        rv_a_d   = 1'b1;
                        rv_b_d   = 1'b1;
                        err_d    = !match;
                        mismatch = !match;
                        state_d  = match ? MEM : RESP;
                    end else if (state_q == IDLE) begin
                        if (a_req_i || b_req_i) begin
                            skew_d   = SK_W'(1);
                            lone_a_d = a_req_i;
                            state_d  = SYNC;
                        end
                    end else if (skew_q == SK_W'(SKEW_MAX)) begin
                        gnt_a    = lone_a_q;
                        gnt_b    = !lone_a_q;
                        rv_a_d   = lone_a_q;
                        rv_b_d   = !lone_a_q;
                        err_d    = 1'b1;
                        mismatch = 1'b1;
                        timeout  = 1'b1;
                        state_d  = RESP;
                    end else begin
                        skew_d = skew_q + SK_W'(1);
                    end
                end
                MEM:     state_d = RESP;
                RESP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State, latched request fields and saturating mismatch counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            skew_q   <= '0;
            lone_a_q <= 1'b0;
            quiet_q  <= 1'b1;
            rv_a_q   <= 1'b0;
            rv_b_q   <= 1'b0;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            skew_q   <= skew_d;
            lone_a_q <= lone_a_d;
            quiet_q  <= 1'b0;
            rv_a_q   <= rv_a_d;
            rv_b_q   <= rv_b_d;
            err_q    <= err_d;
            if (lat) begin
                we_q    <= a_we_i;
                be_q    <= a_be_i;
                addr_q  <= a_addr_i;
                wdata_q <= a_wdata_i;
            end
            if (mismatch && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign in_mem  = (state_q == MEM) && !rst_i;
    assign in_resp = (state_q == RESP) && !rst_i;

    assign a_gnt_o        = gnt_a;
    assign b_gnt_o        = gnt_b;
    assign mismatch_o     = mismatch;
    assign skew_timeout_o = timeout;
    assign mismatch_cnt_o = rst_i ? '0 : cnt_q;

    assign mem_req_o   = in_mem;
    assign mem_we_o    = in_mem && we_q;
    assign mem_be_o    = in_mem ? be_q : '0;
    assign mem_addr_o  = in_mem ? addr_q : '0;
    assign mem_wdata_o = in_mem ? wdata_q : '0;

    assign a_rvalid_o = in_resp && rv_a_q;
    assign b_rvalid_o = in_resp && rv_b_q;
    assign a_err_o    = in_resp && rv_a_q && err_q;
    assign b_err_o    = in_resp && rv_b_q && err_q;
    assign a_rdata_o  = (in_resp && !err_q && !we_q) ? mem_rdata_i : '0;
    assign b_rdata_o  = (in_resp && !err_q && !we_q) ? mem_rdata_i : '0;

endmodule
